// File: rtl/fetch_sequencer.sv
// fetch_sequencer: drives PC load/offset controls, owns a circular return-address stack and halt/resume.
// Optional FETCH_SEQ_SIGNED_BRANCH_EN: signed branches via LoadValue instead of unsigned OffsetEnable.
module fetch_sequencer #(
  parameter int          RAS_DEPTH    = 4,
  parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] PcValue,
  input  logic        FetchReady,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [8:0]  BranchOffset,
  input  logic        Jump,
  input  logic        Call,
  input  logic [15:0] JumpTarget,
  input  logic        Return,
  input  logic        Halt,
  input  logic        Resume,
  output logic        LoadEnable,
  output logic [15:0] LoadValue,
  output logic        OffsetEnable,
  output logic [8:0]  Offset,
  output logic        FetchValid,
  output logic        RasOverflow,
  output logic        RasUnderflow
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);
  typedef enum logic [1:0] {START, FETCH, REDIRECT, HALT} state_t;
  state_t state_q, state_d;
  logic [15:0] ras_q [RAS_DEPTH];
  logic [15:0] ras_d [RAS_DEPTH];
  logic [PW-1:0] wp_q, wp_d, top;
  logic [PW:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, unf_q, unf_d, redir, empty;
  assign top = wp_q - PW'(1);
  assign empty = cnt_q == '0;
  assign redir = !Stall && (Return || Call || Jump || BranchTaken);
  assign RasOverflow = ovf_q;
  assign RasUnderflow = unf_q;
  always_comb begin
    state_d = state_q;
    ras_d = ras_q;
    wp_d = wp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    LoadEnable = 1'b1;
    LoadValue = PcValue;
    OffsetEnable = 1'b0;
    Offset = '0;
    FetchValid = 1'b0;
    case (state_q)
      START: begin
        LoadValue = RESET_VECTOR;
        state_d = FETCH;
      end
      FETCH: begin
        FetchValid = 1'b1;
        if (Halt) state_d = HALT;
        else if (redir) begin
          state_d = REDIRECT;
          if (Return) begin
            LoadValue = empty ? RESET_VECTOR : ras_q[top];
            unf_d = unf_q | empty;
            wp_d = empty ? wp_q : top;
            cnt_d = empty ? cnt_q : cnt_q - (PW+1)'(1);
          end else if (Call || Jump) begin
            LoadValue = JumpTarget;
            // a full stack overwrites its oldest slot, which is exactly the next write slot
            if (Call) begin
              ras_d[wp_q] = PcValue + 16'd1;
              wp_d = wp_q + PW'(1);
              ovf_d = ovf_q | (cnt_q == FULL);
              cnt_d = (cnt_q == FULL) ? cnt_q : cnt_q + (PW+1)'(1);
            end
          end else begin
`ifdef FETCH_SEQ_SIGNED_BRANCH_EN
            LoadValue = PcValue + {{7{BranchOffset[8]}}, BranchOffset};
`else
            LoadEnable = 1'b0;
            LoadValue = '0;
            OffsetEnable = 1'b1;
            Offset = BranchOffset;
`endif
          end
        end else if (!Stall && FetchReady) begin
          LoadEnable = 1'b0;
          LoadValue = '0;
        end
      end
      REDIRECT: state_d = FETCH;
      default: state_d = Resume ? FETCH : HALT;
    endcase
  end
  always_ff @(posedge Clock) begin
    ras_q <= ras_d;
    if (Reset) begin
      state_q <= START;
      wp_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q <= wp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios plus randomized traffic against a queue-based sequencer model.
module tb_fetch_sequencer;
  localparam int D = 4;
  localparam logic [15:0] RV = 16'h0100;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, fr, stall, br, jmp, call, ret, halt, res;
  logic [8:0] bo, off;
  logic [15:0] jt, pc, lv;
  logic le, oe, fv, ovf, unf;
  logic fv_s, le_s, oe_s;
  logic [15:0] lv_s;
  logic [8:0] off_s;
  int n_cmp = 0, n_bad = 0;
  bit m_started, m_bubble, m_halted, m_ovf, m_unf, e_fv;
  logic [15:0] e_pc;
  logic [15:0] q[$];
  logic [15:0] pushed[5];

  fetch_sequencer #(.RAS_DEPTH(D), .RESET_VECTOR(RV)) dut (
    .Clock(clk), .Reset(rst), .PcValue(pc), .FetchReady(fr), .Stall(stall),
    .BranchTaken(br), .BranchOffset(bo), .Jump(jmp), .Call(call), .JumpTarget(jt),
    .Return(ret), .Halt(halt), .Resume(res), .LoadEnable(le), .LoadValue(lv),
    .OffsetEnable(oe), .Offset(off), .FetchValid(fv), .RasOverflow(ovf), .RasUnderflow(unf)
  );

  // the program counter the sequencer steers
  always @(posedge clk) pc <= rst ? 16'h0 : le ? lv : oe ? pc + {7'b0, off} : pc + 16'd1;

  task automatic idle();
    fr = 1; stall = 0; br = 0; jmp = 0; call = 0; ret = 0; halt = 0; res = 0; bo = 0; jt = 0;
  endtask

  task automatic predict();
    logic [15:0] nx;
    nx = e_pc;
    if (rst) begin
      m_started = 0; m_bubble = 0; m_halted = 0; m_ovf = 0; m_unf = 0;
      q.delete(); e_fv = 0; e_pc = 16'h0;
      return;
    end
    if (!m_started) begin e_fv = 0; m_started = 1; nx = RV; end
    else if (m_bubble) begin e_fv = 0; m_bubble = 0; end
    else if (m_halted) begin e_fv = 0; if (res) m_halted = 0; end
    else begin
      e_fv = 1;
      if (halt) m_halted = 1;
      else if (!stall && (ret || call || jmp || br)) begin
        m_bubble = 1;
        if (ret) begin
          if (q.size() == 0) begin nx = RV; m_unf = 1; end
          else nx = q.pop_back();
        end else if (call) begin
          nx = jt;
          q.push_back(16'(int'(e_pc) + 1));
          if (q.size() > D) begin void'(q.pop_front()); m_ovf = 1; end
        end else if (jmp) nx = jt;
`ifdef FETCH_SEQ_SIGNED_BRANCH_EN
        else nx = 16'(int'(e_pc) + int'($signed(bo)));
`else
        else nx = 16'(int'(e_pc) + int'(bo));
`endif
      end else if (!stall && fr) nx = 16'(int'(e_pc) + 1);
    end
    e_pc = nx;
  endtask

  task automatic step();
    #1;
    fv_s = fv; le_s = le; oe_s = oe; lv_s = lv; off_s = off;
    predict();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_pc(input logic [15:0] a);
    idle(); jmp = 1; jt = a; step();
    idle(); step();
  endtask

  task automatic do_reset();
    idle(); rst = 1; step();
    rst = 0; step();
  endtask

  task automatic test_reset();
    idle(); rst = 1; step(); step();
    rst = 0; step();
    n_cmp++; if (fv_s !== 1'b0) begin n_bad++; $display("FAIL reset_start_fv: got %b want 0", fv_s); end
    n_cmp++; if (le_s !== 1'b1 || lv_s !== RV) begin n_bad++; $display("FAIL reset_start_load: got le=%b lv=%h want le=1 lv=%h", le_s, lv_s, RV); end
    n_cmp++; if (pc !== RV) begin n_bad++; $display("FAIL reset_pc: got %h want %h", pc, RV); end
    n_cmp++; if (ovf !== 1'b0 || unf !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got ovf=%b unf=%b want 0 0", ovf, unf); end
    step();
    n_cmp++; if (fv_s !== 1'b1 || pc !== 16'h0101) begin n_bad++; $display("FAIL reset_first_fetch: got fv=%b pc=%h want fv=1 pc=0101", fv_s, pc); end
    step();
    n_cmp++; if (pc !== 16'h0102) begin n_bad++; $display("FAIL reset_second_inc: got %h want 0102", pc); end
  endtask

  task automatic test_hold();
    goto_pc(16'h0010);
    fr = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (le_s !== 1'b1 || lv_s !== 16'h0010 || pc !== 16'h0010) begin n_bad++; $display("FAIL hold_%0d: got le=%b lv=%h pc=%h want le=1 lv=0010 pc=0010", i, le_s, lv_s, pc); end
    end
    fr = 1; step();
    n_cmp++; if (le_s !== 1'b0 || oe_s !== 1'b0 || pc !== 16'h0011) begin n_bad++; $display("FAIL hold_release: got le=%b oe=%b pc=%h want 0 0 0011", le_s, oe_s, pc); end
  endtask

  task automatic test_call_return();
    goto_pc(16'h0020);
    call = 1; jt = 16'h0400; step();
    n_cmp++; if (le_s !== 1'b1 || lv_s !== 16'h0400 || pc !== 16'h0400) begin n_bad++; $display("FAIL call_target: got le=%b lv=%h pc=%h want 1 0400 0400", le_s, lv_s, pc); end
    idle(); step();
    n_cmp++; if (fv_s !== 1'b0 || pc !== 16'h0400) begin n_bad++; $display("FAIL call_bubble: got fv=%b pc=%h want 0 0400", fv_s, pc); end
    step(); step();
    ret = 1; step();
    n_cmp++; if (lv_s !== 16'h0021 || pc !== 16'h0021) begin n_bad++; $display("FAIL return_addr: got lv=%h pc=%h want 0021", lv_s, pc); end
    idle(); step();
    n_cmp++; if (fv_s !== 1'b0 || pc !== 16'h0021) begin n_bad++; $display("FAIL return_bubble: got fv=%b pc=%h want 0 0021", fv_s, pc); end
  endtask

  task automatic test_ras_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      goto_pc(16'h1000 + 16'(i * 16));
      pushed[i] = 16'h1001 + 16'(i * 16);
      call = 1; jt = 16'h2000 + 16'(i); step();
      idle(); step();
      n_cmp++; if (ovf !== (i == 4)) begin n_bad++; $display("FAIL ras_ovf_call%0d: got %b want %b", i, ovf, i == 4); end
    end
    for (int k = 0; k < 5; k++) begin
      ret = 1; step();
      idle(); step();
      n_cmp++; if (pc !== ((k < 4) ? pushed[4-k] : RV)) begin n_bad++; $display("FAIL ras_pop%0d: got %h want %h", k, pc, (k < 4) ? pushed[4-k] : RV); end
      n_cmp++; if (unf !== (k == 4)) begin n_bad++; $display("FAIL ras_unf_pop%0d: got %b want %b", k, unf, k == 4); end
    end
  endtask

  task automatic test_branch();
    goto_pc(16'h0050);
    br = 1; bo = 9'h1F0; step();
    idle();
`ifdef FETCH_SEQ_SIGNED_BRANCH_EN
    n_cmp++; if (le_s !== 1'b1 || oe_s !== 1'b0 || pc !== 16'h0040) begin n_bad++; $display("FAIL branch_signed: got le=%b oe=%b pc=%h want 1 0 0040", le_s, oe_s, pc); end
`else
    n_cmp++; if (le_s !== 1'b0 || oe_s !== 1'b1 || off_s !== 9'h1F0 || pc !== 16'h0240) begin n_bad++; $display("FAIL branch_unsigned: got le=%b oe=%b off=%h pc=%h want 0 1 1f0 0240", le_s, oe_s, off_s, pc); end
`endif
    step();
    n_cmp++; if (fv_s !== 1'b0) begin n_bad++; $display("FAIL branch_bubble: got fv=%b want 0", fv_s); end
  endtask

  task automatic test_priority();
    do_reset();
    goto_pc(16'h0030);
    call = 1; jt = 16'h0200; step();
    idle(); step();
    ret = 1; call = 1; jmp = 1; jt = 16'h0999; step();
    n_cmp++; if (pc !== 16'h0031) begin n_bad++; $display("FAIL prio_return_wins: got %h want 0031", pc); end
    idle(); step();
    goto_pc(16'h0060);
    call = 1; jt = 16'h0300; step();
    idle(); step();
    stall = 1; ret = 1; call = 1; jmp = 1; jt = 16'h0777; step();
    n_cmp++; if (le_s !== 1'b1 || lv_s !== 16'h0300 || pc !== 16'h0300) begin n_bad++; $display("FAIL prio_stall_hold: got le=%b lv=%h pc=%h want 1 0300 0300", le_s, lv_s, pc); end
    idle(); ret = 1; step();
    n_cmp++; if (pc !== 16'h0061) begin n_bad++; $display("FAIL prio_stall_no_push: got %h want 0061", pc); end
    idle(); step();
    ret = 1; step();
    n_cmp++; if (pc !== RV || unf !== 1'b1) begin n_bad++; $display("FAIL prio_single_push: got pc=%h unf=%b want %h 1", pc, unf, RV); end
    idle(); step();
  endtask

  task automatic test_halt();
    goto_pc(16'h0070);
    halt = 1; step();
    n_cmp++; if (fv_s !== 1'b1 || pc !== 16'h0070) begin n_bad++; $display("FAIL halt_enter: got fv=%b pc=%h want 1 0070", fv_s, pc); end
    idle(); jmp = 1; jt = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (fv_s !== 1'b0 || pc !== 16'h0070) begin n_bad++; $display("FAIL halt_hold_%0d: got fv=%b pc=%h want 0 0070", i, fv_s, pc); end
    end
    idle(); res = 1; step();
    n_cmp++; if (fv_s !== 1'b0 || pc !== 16'h0070) begin n_bad++; $display("FAIL halt_resume_cycle: got fv=%b pc=%h want 0 0070", fv_s, pc); end
    idle(); step();
    n_cmp++; if (fv_s !== 1'b1 || pc !== 16'h0071) begin n_bad++; $display("FAIL halt_after_resume: got fv=%b pc=%h want 1 0071", fv_s, pc); end
  endtask

  task automatic test_random();
    bit r;
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 63) == 0;
      rst = r;
      fr = $urandom_range(0, 3) != 0;
      stall = $urandom_range(0, 3) == 0;
      br = $urandom_range(0, 7) == 0;
      jmp = $urandom_range(0, 7) == 0;
      call = $urandom_range(0, 5) == 0;
      ret = $urandom_range(0, 5) == 0;
      halt = $urandom_range(0, 19) == 0;
      res = $urandom_range(0, 2) == 0;
      bo = 9'($urandom);
      jt = 16'($urandom);
      step();
      if (!r) begin
        n_cmp++; if (fv_s !== e_fv) begin n_bad++; $display("FAIL rand_fv@%0d: got %b want %b", i, fv_s, e_fv); end
        n_cmp++; if ((le_s && oe_s) || (!le_s && lv_s !== 16'h0) || (!oe_s && off_s !== 9'h0)) begin n_bad++; $display("FAIL rand_enables@%0d: got le=%b lv=%h oe=%b off=%h want exclusive with idle zeros", i, le_s, lv_s, oe_s, off_s); end
      end
      n_cmp++; if (pc !== e_pc) begin n_bad++; $display("FAIL rand_pc@%0d: got %h want %h", i, pc, e_pc); end
      n_cmp++; if (ovf !== m_ovf || unf !== m_unf) begin n_bad++; $display("FAIL rand_flags@%0d: got ovf=%b unf=%b want %b %b", i, ovf, unf, m_ovf, m_unf); end
    end
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_hold();
    test_call_return();
    test_ras_overflow();
    test_branch();
    test_priority();
    test_halt();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
